// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with valid/ready request and response handshakes
//
// Purpose: accepts one load/store at a time, waits WAIT_CYCLES extra cycles, then
// performs a byte/half/word access with lane placement and load extension. The
// result is held on the response channel until the core takes it.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_addr,
//   req_wdata, req_funct3      store flag, byte address, store data, RV32I size code
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err       extended load data (0 on stores/errors), error flag
//   seg_out                    display register, only with DMEM_MMIO_SEG_EN
//
// Optional feature: define DMEM_MMIO_SEG_EN to map byte address 0xFFFF_FFF0 to seg_out.
module dmem_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int ADDR_SIZE   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_MMIO_SEG_EN
    ,
    output logic [31:0] seg_out
`endif
);
    localparam int CW = $clog2(WAIT_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [31:0]            mem_q [MEM_WORDS];

    logic [ADDR_SIZE-1:0]   word_idx;
    logic                   idx_ok, range_ok, f_ok, misalign, mmio, acc_err, do_store;
    logic [31:0]            rd_word, sh, load_val, wdata_sh;
    logic [3:0]             be;

`ifdef DMEM_MMIO_SEG_EN
    logic [31:0]            seg_q, seg_d;
    assign seg_out = seg_q;
    assign mmio    = addr_q == 32'hFFFF_FFF0;
    assign rd_word = mmio ? seg_q : mem_q[word_idx];
`else
    assign mmio    = 1'b0;
    assign rd_word = mem_q[word_idx];
`endif

    assign word_idx = addr_q[ADDR_SIZE+1:2];

    // A word index can only exceed the array when the array is smaller than the index space.
    if (MEM_WORDS >= (1 << ADDR_SIZE)) begin : g_full
        assign idx_ok = 1'b1;
    end else begin : g_part
        assign idx_ok = {{(32-ADDR_SIZE){1'b0}}, word_idx} < 32'(MEM_WORDS);
    end

    assign range_ok = (addr_q[31:ADDR_SIZE+2] == '0) && idx_ok;
    assign f_ok     = we_q ? (funct3_q inside {3'b000, 3'b001, 3'b010})
                           : (funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misalign = (funct3_q[1:0] == 2'b01 && addr_q[0]) ||
                      (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    // The MMIO register only supports whole-word access; everything else must hit the array.
    assign acc_err  = !f_ok || misalign || (mmio ? funct3_q != 3'b010 : !range_ok);

    assign sh       = rd_word >> {addr_q[1:0], 3'b000};
    assign load_val = funct3_q[1] ? rd_word
                    : funct3_q[0] ? {{16{~funct3_q[2] & sh[15]}}, sh[15:0]}
                    :               {{24{~funct3_q[2] & sh[7]}},  sh[7:0]};
    assign be       = funct3_q[1] ? 4'hF
                    : funct3_q[0] ? 4'b0011 << {addr_q[1], 1'b0}
                    :               4'b0001 << addr_q[1:0];
    assign wdata_sh = wdata_q << {addr_q[1:0], 3'b000};

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        do_store = 1'b0;
`ifdef DMEM_MMIO_SEG_EN
        seg_d    = seg_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                we_d     = req_we;
                addr_d   = req_addr;
                wdata_d  = req_wdata;
                funct3_d = req_funct3;
                cnt_d    = CW'(WAIT_CYCLES);
                state_d  = ACCESS;
            end
            ACCESS: if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d  = RESP;
                err_d    = acc_err;
                rdata_d  = (acc_err || we_q) ? 32'h0 : load_val;
                do_store = we_q && !acc_err && !mmio;
`ifdef DMEM_MMIO_SEG_EN
                if (we_q && mmio && !acc_err) seg_d = wdata_q;
`endif
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef DMEM_MMIO_SEG_EN
            seg_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef DMEM_MMIO_SEG_EN
            seg_q    <= seg_d;
`endif
        end
    end

    // Array is not reset; a reset forces IDLE asynchronously so no write fires afterwards.
    always_ff @(posedge clk) begin
        if (do_store)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
`ifdef DMEM_MMIO_SEG_EN
    logic [31:0] seg_out;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int lat;
    logic [31:0] rd;
    logic        er;

    dmem_responder #(.MEM_WORDS(1024), .ADDR_SIZE(10), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef DMEM_MMIO_SEG_EN
        , .seg_out(seg_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_funct3 = f;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (n < 20 && !resp_valid) begin
            @(posedge clk);
            #1 n++;
        end
        if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        send(we, a, d, f);
        wait_resp(lat);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", 32'(resp_err), 32'd0);
`ifdef DMEM_MMIO_SEG_EN
        check("rst_seg", seg_out, 32'h0);
`endif
        @(negedge clk) rst = 1'b1;

        txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        check("sw_err", 32'(er), 32'd0);
        check("sw_latency", 32'(lat), 32'(WAIT + 1));
        check("sw_rdata", rd, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 3'b010);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", 32'(er), 32'd0);
        check("lw_latency", 32'(lat), 32'(WAIT + 1));

        txn(1'b1, 32'h20, 32'h0, 3'b010);
        txn(1'b1, 32'h22, 32'h80, 3'b000);
        check("sb_err", 32'(er), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 3'b010);
        check("lw_lane", rd, 32'h00800000);
        txn(1'b0, 32'h22, 32'h0, 3'b000);
        check("lb_sign", rd, 32'hFFFFFF80);
        txn(1'b0, 32'h22, 32'h0, 3'b100);
        check("lbu_zero", rd, 32'h00000080);
        txn(1'b1, 32'h22, 32'h1234BEEF, 3'b001);
        txn(1'b0, 32'h20, 32'h0, 3'b010);
        check("sh_lane", rd, 32'hBEEF0000);
        txn(1'b0, 32'h22, 32'h0, 3'b001);
        check("lh_sign", rd, 32'hFFFFBEEF);
        txn(1'b0, 32'h22, 32'h0, 3'b101);
        check("lhu_zero", rd, 32'h0000BEEF);

        txn(1'b1, 32'h30, 32'h12345678, 3'b010);
        txn(1'b1, 32'h31, 32'h0000AAAA, 3'b001);
        check("sh_misalign_err", 32'(er), 32'd1);
        check("sh_misalign_rdata", rd, 32'h0);
        txn(1'b0, 32'h30, 32'h0, 3'b010);
        check("misalign_nowrite", rd, 32'h12345678);
        txn(1'b0, 32'h32, 32'h0, 3'b010);
        check("lw_misalign_err", 32'(er), 32'd1);
        txn(1'b0, 32'h1000, 32'h0, 3'b010);
        check("range_err", 32'(er), 32'd1);
        txn(1'b0, 32'hFFC, 32'h0, 3'b010);
        check("top_word_ok", 32'(er), 32'd0);
        txn(1'b0, 32'h30, 32'h0, 3'b011);
        check("ld_f011_err", 32'(er), 32'd1);
        check("ld_f011_rdata", rd, 32'h0);
        txn(1'b1, 32'h30, 32'hFFFFFFFF, 3'b100);
        check("st_f100_err", 32'(er), 32'd1);
        txn(1'b0, 32'h30, 32'h0, 3'b010);
        check("st_f100_nowrite", rd, 32'h12345678);

        resp_ready = 1'b0;
        send(1'b0, 32'h30, 32'h0, 3'b010);
        wait_resp(lat);
        check("bp_latency", 32'(lat), 32'(WAIT + 1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, 32'h12345678);
            check("bp_err", 32'(resp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(resp_valid), 32'd0);

        txn(1'b1, 32'h40, 32'h0, 3'b010);
        txn(1'b0, 32'h10, 32'h0, 3'b010);
        send(1'b1, 32'h40, 32'h11111111, 3'b010);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'h0);
        check("mid_rst_err", 32'(resp_err), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        txn(1'b0, 32'h40, 32'h0, 3'b010);
        check("mid_rst_nowrite", rd, 32'h0);

        txn(1'b1, 32'hFFFFFFF0, 32'h00000042, 3'b010);
`ifdef DMEM_MMIO_SEG_EN
        check("mmio_sw_err", 32'(er), 32'd0);
        check("mmio_seg", seg_out, 32'h42);
        txn(1'b0, 32'hFFFFFFF0, 32'h0, 3'b010);
        check("mmio_lw", rd, 32'h42);
        txn(1'b1, 32'hFFFFFFF0, 32'h0, 3'b000);
        check("mmio_sb_err", 32'(er), 32'd1);
        check("mmio_sb_keep", seg_out, 32'h42);
`else
        check("mmio_off_err", 32'(er), 32'd1);
        txn(1'b0, 32'hFFFFFFF0, 32'h0, 3'b010);
        check("mmio_off_lw_err", 32'(er), 32'd1);
        check("mmio_off_lw_rdata", rd, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multi-cycle core's load/store stage. It accepts one request at a time over a valid/ready handshake and applies configurable wait states. It performs byte/half/word accesses with lane placement and load sign/zero extension, then returns the result over a second valid/ready handshake. It sits between the core's memory-access stage and the data RAM, and replaces the single-cycle combinational memory path.

## Interface
- MEM_WORDS, 1024, depth of the 32-bit word array.
- ADDR_SIZE, 10, word-index bits; byte address bits [ADDR_SIZE+1:2] select the word.
- WAIT_CYCLES, 2, extra access cycles inserted before the memory operation (0 legal).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bytes are used per size.
- req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range, or illegal funct3.
- seg_out  out  32  memory-mapped display register; present only with DMEM_MMIO_SEG_EN.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - req_ready=1.
  - When req_valid&&req_ready at a rising edge: latch we, addr, wdata, funct3; load the wait counter with WAIT_CYCLES; go to ACCESS.
- **ACCESS**
  - req_ready=0.
  - If counter≠0, decrement.
  - At the edge where counter==0, perform the operation and go to RESP.
  - Stores write only the selected byte lanes:
    - B: lane addr[1:0].
    - H: lanes {addr[1],x}.
    - W: all lanes.
  - Loads read the word, select the lane, then extend:
    - B and H are sign-extended.
    - BU and HU are zero-extended.
    - W is returned unchanged.
- **RESP**
  - resp_valid=1. resp_rdata and resp_err are held stable until resp_valid&&resp_ready.
  - On that edge, go to IDLE.
- **Errors** (flag resp_err; no memory write; resp_rdata=0):
  - H access with addr[0]=1.
  - W access with addr[1:0]≠0.
  - addr[31:ADDR_SIZE+2]≠0, except the MMIO address.
  - Stores with funct3 ∉ {000,001,010}.
  - Loads with funct3 ∈ {011,110,111}.
- **Write-read ordering:** a store completes before its response, so a following load always observes it.

## Timing
- Request accepted at edge E0.
- ACCESS occupies WAIT_CYCLES+1 cycles.
- resp_valid rises after edge E0+WAIT_CYCLES+1.
- The earliest response handshake is that same cycle. IDLE (req_ready=1) follows the handshake edge.
- Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- **Reset values:**
  - State IDLE.
  - req_ready=1.
  - resp_valid=0.
  - resp_rdata=0.
  - resp_err=0.
  - seg_out=0.
  - Array contents are not reset.
- **Reset mid-operation:** returns immediately to IDLE. A store whose operation edge has not been reached is not committed. A pending response is dropped.
- req_valid while not ready is ignored, with no latching. The initiator must hold its request until accepted.
- resp_ready while resp_valid=0 has no effect.

## Configuration
- **DMEM_MMIO_SEG_EN defined:**
  - Byte address 0xFFFF_FFF0 maps to a 32-bit register driving seg_out.
  - W store sets the register. W load returns it.
  - B/H accesses to this address set resp_err.
  - The register is updated at the operation edge.
- **DMEM_MMIO_SEG_EN undefined:**
  - seg_out port and register are absent.
  - 0xFFFF_FFF0 is out of range, so accesses to it set resp_err.

## Test plan
- **Word round trip:** SW 0xDEADBEEF at 0x10, then LW 0x10 → resp_rdata=0xDEADBEEF, resp_err=0. resp_valid rises exactly WAIT_CYCLES+1 cycles after each accept.
- **Byte lanes:**
  - Preload word 0x0 at 0x20, then SB 0x80 at 0x22.
  - LW 0x20 → 0x00800000.
  - LB 0x22 → 0xFFFFFF80.
  - LBU 0x22 → 0x00000080.
- **Misaligned half:** SW 0x12345678 at 0x30, then SH 0xAAAA at 0x31 → resp_err=1. A following LW 0x30 → 0x12345678, unchanged.
- **Backpressure:** hold resp_ready=0 for 5 cycles after resp_valid → resp_valid, resp_rdata and resp_err stay stable, and req_ready stays 0. Release → IDLE next cycle.
- **Reset mid-access:** SW 0x11111111 to 0x40 (prior value 0x0), and assert rst low during the first ACCESS cycle with WAIT_CYCLES=2 → outputs take their reset values asynchronously. A later LW 0x40 → 0x00000000.
- **MMIO (macro on):** SW 0x00000042 at 0xFFFF_FFF0 → seg_out=0x42 after the operation edge. LW returns 0x42. With the macro off, the same SW sets resp_err=1.
